muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Sequences the ALU/MUL/DIV execute group's multiplier and divider. Accepts MUL/DIV micro-ops from the register-read stage through a valid/ready handshake. Issues each op to the pipelined fast multiplier (fixed latency) or to the iterative divider (variable latency), tracks in-flight ROB tags and PRF destinations, and applies branch/ROB kills. Arbitrates both completion streams onto one muldiv writeback/broadcast port.

Parameters:
XLEN, 32, data width
TAG_W, 5, ROB tag width
PRF_W, 6, physical register specifier width
MUL_LAT, 2, multiplier latency in cycles from mul_req_o to mul_result_i (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req_valid_i  in  1  op offered by register-read stage
req_ready_o  out  1  op accepted when valid&&ready
req_is_div_i  in  1  1=DIV/REM, 0=MUL family
req_op_i  in  2  ctrl_signal[1:0] operation select
req_a_i / req_b_i  in  XLEN  operands, already bypassed
req_tag_i  in  TAG_W  ROB tag
req_rd_i  in  PRF_W  destination PRF
stall_i  in  1  recovery stall; freezes sequencer
flush_valid_i  in  1  branch recovery broadcast
flush_tag_i  in  TAG_W  mispredicted branch tag
rob_head_i  in  TAG_W  ROB head, used for age compare
mul_req_o  out  1  multiplier start
mul_op_o  out  2  multiplier op
mul_a_o / mul_b_o  out  XLEN  multiplier operands
mul_result_i  in  XLEN  multiplier result, valid MUL_LAT cycles after mul_req_o
div_req_o  out  1  divider start pulse
div_kill_o  out  1  abort divider
div_op_o  out  2  divider op
div_a_o / div_b_o  out  XLEN  divider operands
div_done_i  in  1  divider result valid (1-cycle pulse)
div_result_i  in  XLEN  divider result
wb_valid_o  out  1  writeback/commit valid
wb_rd_o  out  PRF_W  writeback PRF
wb_tag_o  out  TAG_W  ROB tag to commit
wb_data_o  out  XLEN  result
bcast_valid_o  out  1  wakeup broadcast to IQs/busy list
bcast_rd_o  out  PRF_W  wakeup PRF
busy_o  out  1  divider path occupied; tells issue queue to hold DIVs

Behaviour:
- Reset: all outputs and state are 0. No in-flight entries. Reset mid-operation discards everything and does not assert div_kill_o.
- Age compare: age(t)=(t-rob_head_i) mod 2^TAG_W. An entry is killed when flush_valid_i && age(t)>age(flush_tag_i). The branch itself survives.
- req_ready_o = !stall_i && (!req_is_div_i || (!div_busy && !skid_valid)). This is combinational on req_is_div_i.
- An accepted request that is killed in the same cycle is dropped: no mul_req_o/div_req_o and no tracking.
- MUL path:
  - mul_req_o, mul_op_o and operands are driven combinationally in the acceptance cycle.
  - {valid,tag,rd} enters an MUL_LAT-deep tracking shift register.
  - At the tail, mul_result_i is written back. wb_valid_o is registered, giving wb at acceptance+MUL_LAT+1.
  - A kill clears the valid bit of matching stages.
- DIV path, with states IDLE, ISSUE, RUN:
  - On acceptance, operands/op/tag/rd are registered and the FSM goes to ISSUE.
  - ISSUE pulses div_req_o for 1 cycle, then goes to RUN.
  - In RUN, div_done_i goes to IDLE and presents the result for writeback.
  - A kill in ISSUE or RUN pulses div_kill_o, returns to IDLE and drops any same-cycle div_done_i.
  - div_busy = (state!=IDLE).
- Collision: when the mul tail and div_done_i are valid in the same cycle, MUL wins and the div result goes to a 1-entry skid buffer.
  - The skid drains on the first cycle with no mul tail valid.
  - The skid cannot be overwritten, because a new DIV is not accepted while div_busy||skid_valid.
  - A kill also clears a matching skid entry.
- busy_o is registered = div_busy||skid_valid after update.
- Stall: while stall_i=1, the FSM, tracking register, skid and wb/bcast outputs all hold. No new req, div_req_o and mul_req_o are 0.
- Kills are still evaluated during stall and clear valid bits. Held wb_valid_o is cleared if its tag is killed.
- bcast_valid_o/bcast_rd_o equal wb_valid_o/wb_rd_o, registered together.

Optional Feature:
MULDIV_EARLY_WAKEUP_EN
- Defined: for MUL entries, bcast_valid_o/bcast_rd_o are asserted one cycle before wb_valid_o, driven from tracking stage MUL_LAT-1. This is safe because MUL always wins arbitration. DIV broadcasts stay coincident with writeback.
- Undefined: broadcast is always coincident with writeback.

Decomposition:
- Falco_pkg holds muldiv_req_t {is_div,op,a,b,tag,rd}, muldiv_trk_t {valid,tag,rd} and the div FSM enum.
- Falco_pkg also holds the function is_younger(tag,flush_tag,head), shared with the age-compare logic.
- One sub-module: muldiv_track_pipe, the MUL_LAT-deep tracking shift register with per-stage kill and stall.

Test Plan:
- MUL tag=3 rd=10 a=6 b=7 at T0, MUL_LAT=2 -> wb_valid_o at T3, wb_tag_o=3, wb_rd_o=10, wb_data_o=42.
- DIV tag=4 at T0 -> div_req_o at T1; div_done_i at T20 with result 5 -> wb at T21. DIV offered at T5 sees req_ready_o=0 and busy_o=1.
- Mul tail and div_done_i both at T10 -> mul written back at T11, div at T12. A second DIV is refused until T12.
- DIV tag=7 in RUN, head=0, flush_tag=5 -> div_kill_o pulse, no wb. A MUL with tag=2 in flight still writes back.
- stall_i high T4–T6 with a MUL accepted at T3 -> wb delayed 3 cycles, no duplicate wb_valid_o.
- MULDIV_EARLY_WAKEUP_EN defined, MUL at T0 -> bcast_valid_o at T2, wb_valid_o at T3. Undefined -> both at T3.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and age-compare helper for the MUL/DIV sequencer.
// Defines the request/tracking records, the divider FSM states and default widths.
package Falco_pkg;

    localparam int MD_XLEN    = 32;
    localparam int MD_TAG_W   = 5;
    localparam int MD_PRF_W   = 6;
    localparam int MD_MUL_LAT = 2;

    typedef struct packed {
        logic                is_div;
        logic [1:0]          op;
        logic [MD_XLEN-1:0]  a;
        logic [MD_XLEN-1:0]  b;
        logic [MD_TAG_W-1:0] tag;
        logic [MD_PRF_W-1:0] rd;
    } muldiv_req_t;

    typedef struct packed {
        logic                valid;
        logic [MD_TAG_W-1:0] tag;
        logic [MD_PRF_W-1:0] rd;
    } muldiv_trk_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ISSUE,
        DIV_RUN
    } div_state_t;

    // Age is the distance from the ROB head; the flushing branch itself is not younger than itself.
    function automatic logic is_younger(input logic [MD_TAG_W-1:0] tag,
                                        input logic [MD_TAG_W-1:0] flush_tag,
                                        input logic [MD_TAG_W-1:0] head);
        logic [MD_TAG_W-1:0] age_t;
        logic [MD_TAG_W-1:0] age_f;
        age_t = tag - head;
        age_f = flush_tag - head;
        return age_t > age_f;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_track_pipe.sv
// MUL_LAT-deep shift register tracking in-flight multiplies, with per-stage kill and stall hold.
// MULDIV_EARLY_WAKEUP_EN adds an output exposing the stage one cycle ahead of the tail.
module muldiv_track_pipe
    import Falco_pkg::*;
#(
    parameter int DEPTH = MD_MUL_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush_valid,
    input  logic [MD_TAG_W-1:0] flush_tag,
    input  logic [MD_TAG_W-1:0] head,
    input  logic                push_valid,
    input  logic [MD_TAG_W-1:0] push_tag,
    input  logic [MD_PRF_W-1:0] push_rd,
    output logic                tail_valid,
    output logic [MD_TAG_W-1:0] tail_tag,
    output logic [MD_PRF_W-1:0] tail_rd
`ifdef MULDIV_EARLY_WAKEUP_EN
    ,
    output logic                early_valid,
    output logic [MD_TAG_W-1:0] early_tag,
    output logic [MD_PRF_W-1:0] early_rd
`endif
);

    muldiv_trk_t stage_q [DEPTH];
    muldiv_trk_t live    [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = stage_q[i];
            if (flush_valid && is_younger(stage_q[i].tag, flush_tag, head)) begin
                live[i].valid = 1'b0;
            end
        end
    end

    // Killed stages are cleared both when holding and when shifting forward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (stall) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= live[i];
            end
        end else begin
            stage_q[0] <= {push_valid, push_tag, push_rd};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= live[i-1];
            end
        end
    end

    assign tail_valid = live[DEPTH-1].valid;
    assign tail_tag   = live[DEPTH-1].tag;
    assign tail_rd    = live[DEPTH-1].rd;

`ifdef MULDIV_EARLY_WAKEUP_EN
    generate
        if (DEPTH > 1) begin : g_early_stage
            assign early_valid = live[DEPTH-2].valid;
            assign early_tag   = live[DEPTH-2].tag;
            assign early_rd    = live[DEPTH-2].rd;
        end else begin : g_early_push
            assign early_valid = push_valid;
            assign early_tag   = push_tag;
            assign early_rd    = push_rd;
        end
    endgenerate
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences MUL/DIV micro-ops onto a fixed-latency multiplier and an iterative divider, sharing one writeback port.
// Define MULDIV_EARLY_WAKEUP_EN to broadcast MUL wakeups one cycle ahead of writeback.
module muldiv_sequencer
    import Falco_pkg::*;
#(
    parameter int XLEN    = MD_XLEN,
    parameter int TAG_W   = MD_TAG_W,
    parameter int PRF_W   = MD_PRF_W,
    parameter int MUL_LAT = MD_MUL_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_is_div_i,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic [PRF_W-1:0] req_rd_i,
    input  logic             stall_i,
    input  logic             flush_valid_i,
    input  logic [TAG_W-1:0] flush_tag_i,
    input  logic [TAG_W-1:0] rob_head_i,
    output logic             mul_req_o,
    output logic [1:0]       mul_op_o,
    output logic [XLEN-1:0]  mul_a_o,
    output logic [XLEN-1:0]  mul_b_o,
    input  logic [XLEN-1:0]  mul_result_i,
    output logic             div_req_o,
    output logic             div_kill_o,
    output logic [1:0]       div_op_o,
    output logic [XLEN-1:0]  div_a_o,
    output logic [XLEN-1:0]  div_b_o,
    input  logic             div_done_i,
    input  logic [XLEN-1:0]  div_result_i,
    output logic             wb_valid_o,
    output logic [PRF_W-1:0] wb_rd_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic             bcast_valid_o,
    output logic [PRF_W-1:0] bcast_rd_o,
    output logic             busy_o
);

    muldiv_req_t      req;
    div_state_t       state, state_next;
    logic             div_busy, accept, req_killed, mul_accept, div_accept;
    logic [TAG_W-1:0] div_tag;
    logic [PRF_W-1:0] div_rd;
    logic             div_killed, div_fin;
    logic             skid_valid, skid_killed, skid_live, skid_next;
    logic [TAG_W-1:0] skid_tag;
    logic [PRF_W-1:0] skid_rd;
    logic [XLEN-1:0]  skid_data;
    logic             tail_valid;
    logic [TAG_W-1:0] tail_tag;
    logic [PRF_W-1:0] tail_rd;
    logic             mul_block, sel_mul, sel_skid, sel_div, to_skid, wb_killed;
    logic             wb_valid_d;
    logic [TAG_W-1:0] wb_tag_d;
    logic [PRF_W-1:0] wb_rd_d;
    logic [XLEN-1:0]  wb_data_d;
    logic             bcast_valid_d;
    logic [PRF_W-1:0] bcast_rd_d;
`ifdef MULDIV_EARLY_WAKEUP_EN
    logic             early_valid, bcast_killed;
    logic [TAG_W-1:0] early_tag, bcast_tag, bcast_tag_d;
    logic [PRF_W-1:0] early_rd;
`endif

    assign req = '{is_div: req_is_div_i, op: req_op_i, a: req_a_i, b: req_b_i,
                   tag: req_tag_i, rd: req_rd_i};

    assign div_busy    = (state != DIV_IDLE);
    assign req_ready_o = !stall_i && (!req.is_div || (!div_busy && !skid_valid));
    assign accept      = req_valid_i && req_ready_o;
    assign req_killed  = flush_valid_i && is_younger(req.tag, flush_tag_i, rob_head_i);
    assign mul_accept  = accept && !req.is_div && !req_killed;
    assign div_accept  = accept && req.is_div && !req_killed;

    assign mul_req_o = mul_accept;
    assign mul_op_o  = mul_accept ? req.op : '0;
    assign mul_a_o   = mul_accept ? req.a : '0;
    assign mul_b_o   = mul_accept ? req.b : '0;

    assign div_killed  = flush_valid_i && is_younger(div_tag, flush_tag_i, rob_head_i);
    assign skid_killed = flush_valid_i && is_younger(skid_tag, flush_tag_i, rob_head_i);
    assign wb_killed   = flush_valid_i && is_younger(wb_tag_o, flush_tag_i, rob_head_i);
    assign skid_live   = skid_valid && !skid_killed;

    muldiv_track_pipe #(.DEPTH(MUL_LAT)) u_track (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall_i),
        .flush_valid (flush_valid_i),
        .flush_tag   (flush_tag_i),
        .head        (rob_head_i),
        .push_valid  (mul_accept),
        .push_tag    (req.tag),
        .push_rd     (req.rd),
        .tail_valid  (tail_valid),
        .tail_tag    (tail_tag),
        .tail_rd     (tail_rd)
`ifdef MULDIV_EARLY_WAKEUP_EN
        ,
        .early_valid (early_valid),
        .early_tag   (early_tag),
        .early_rd    (early_rd)
`endif
    );

    // A divider completion arriving during stall is still taken (into the skid) so the pulse is never lost.
    always_comb begin
        state_next = state;
        div_req_o  = 1'b0;
        div_kill_o = 1'b0;
        div_fin    = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (div_accept) state_next = DIV_ISSUE;
            end
            DIV_ISSUE: begin
                if (div_killed) begin
                    div_kill_o = 1'b1;
                    state_next = DIV_IDLE;
                end else if (!stall_i) begin
                    div_req_o  = 1'b1;
                    state_next = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (div_killed) begin
                    div_kill_o = 1'b1;
                    state_next = DIV_IDLE;
                end else if (div_done_i) begin
                    div_fin    = 1'b1;
                    state_next = DIV_IDLE;
                end
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    // With early wakeup the pre-tail MUL also blocks DIV, keeping the one-wide broadcast port free for it.
`ifdef MULDIV_EARLY_WAKEUP_EN
    assign mul_block = tail_valid || early_valid;
`else
    assign mul_block = tail_valid;
`endif
    assign sel_mul   = !stall_i && tail_valid;
    assign sel_skid  = !stall_i && !mul_block && skid_live;
    assign sel_div   = !stall_i && !mul_block && !skid_live && div_fin;
    assign to_skid   = div_fin && !sel_div;
    assign skid_next = to_skid || (skid_live && !sel_skid);

    always_comb begin
        wb_valid_d = wb_valid_o && !wb_killed;
        wb_tag_d   = wb_tag_o;
        wb_rd_d    = wb_rd_o;
        wb_data_d  = wb_data_o;
        if (!stall_i) begin
            wb_valid_d = sel_mul || sel_skid || sel_div;
            if (sel_mul) begin
                wb_tag_d  = tail_tag;
                wb_rd_d   = tail_rd;
                wb_data_d = mul_result_i;
            end else if (sel_skid) begin
                wb_tag_d  = skid_tag;
                wb_rd_d   = skid_rd;
                wb_data_d = skid_data;
            end else if (sel_div) begin
                wb_tag_d  = div_tag;
                wb_rd_d   = div_rd;
                wb_data_d = div_result_i;
            end
        end
    end

`ifdef MULDIV_EARLY_WAKEUP_EN
    assign bcast_killed = flush_valid_i && is_younger(bcast_tag, flush_tag_i, rob_head_i);

    always_comb begin
        bcast_valid_d = bcast_valid_o && !bcast_killed;
        bcast_rd_d    = bcast_rd_o;
        bcast_tag_d   = bcast_tag;
        if (!stall_i) begin
            if (early_valid) begin
                bcast_valid_d = 1'b1;
                bcast_rd_d    = early_rd;
                bcast_tag_d   = early_tag;
            end else begin
                bcast_valid_d = sel_skid || sel_div;
                bcast_rd_d    = wb_rd_d;
                bcast_tag_d   = wb_tag_d;
            end
        end
    end
`else
    assign bcast_valid_d = wb_valid_d;
    assign bcast_rd_d    = wb_rd_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= DIV_IDLE;
            div_op_o      <= '0;
            div_a_o       <= '0;
            div_b_o       <= '0;
            div_tag       <= '0;
            div_rd        <= '0;
            skid_valid    <= 1'b0;
            skid_tag      <= '0;
            skid_rd       <= '0;
            skid_data     <= '0;
            wb_valid_o    <= 1'b0;
            wb_tag_o      <= '0;
            wb_rd_o       <= '0;
            wb_data_o     <= '0;
            bcast_valid_o <= 1'b0;
            bcast_rd_o    <= '0;
            busy_o        <= 1'b0;
`ifdef MULDIV_EARLY_WAKEUP_EN
            bcast_tag     <= '0;
`endif
        end else begin
            state <= state_next;
            if (div_accept) begin
                div_op_o <= req.op;
                div_a_o  <= req.a;
                div_b_o  <= req.b;
                div_tag  <= req.tag;
                div_rd   <= req.rd;
            end
            skid_valid <= skid_next;
            if (to_skid) begin
                skid_tag  <= div_tag;
                skid_rd   <= div_rd;
                skid_data <= div_result_i;
            end
            wb_valid_o    <= wb_valid_d;
            wb_tag_o      <= wb_tag_d;
            wb_rd_o       <= wb_rd_d;
            wb_data_o     <= wb_data_d;
            bcast_valid_o <= bcast_valid_d;
            bcast_rd_o    <= bcast_rd_d;
            busy_o        <= (state_next != DIV_IDLE) || skid_next;
`ifdef MULDIV_EARLY_WAKEUP_EN
            bcast_tag     <= bcast_tag_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; bcast timing expectations follow MULDIV_EARLY_WAKEUP_EN.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_is_div_i;
    logic [1:0]  req_op_i;
    logic [31:0] req_a_i, req_b_i;
    logic [4:0]  req_tag_i;
    logic [5:0]  req_rd_i;
    logic        stall_i, flush_valid_i;
    logic [4:0]  flush_tag_i, rob_head_i;
    logic        mul_req_o;
    logic [1:0]  mul_op_o;
    logic [31:0] mul_a_o, mul_b_o, mul_result_i;
    logic        div_req_o, div_kill_o;
    logic [1:0]  div_op_o;
    logic [31:0] div_a_o, div_b_o;
    logic        div_done_i;
    logic [31:0] div_result_i;
    logic        wb_valid_o;
    logic [5:0]  wb_rd_o;
    logic [4:0]  wb_tag_o;
    logic [31:0] wb_data_o;
    logic        bcast_valid_o;
    logic [5:0]  bcast_rd_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_div_i(req_is_div_i),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_tag_i(req_tag_i), .req_rd_i(req_rd_i),
        .stall_i(stall_i), .flush_valid_i(flush_valid_i), .flush_tag_i(flush_tag_i),
        .rob_head_i(rob_head_i),
        .mul_req_o(mul_req_o), .mul_op_o(mul_op_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_result_i(mul_result_i),
        .div_req_o(div_req_o), .div_kill_o(div_kill_o), .div_op_o(div_op_o),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_done_i(div_done_i), .div_result_i(div_result_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o),
        .bcast_valid_o(bcast_valid_o), .bcast_rd_o(bcast_rd_o), .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic valid, input logic is_div, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] tag, input logic [5:0] rd);
        req_valid_i  = valid;
        req_is_div_i = is_div;
        req_op_i     = op;
        req_a_i      = a;
        req_b_i      = b;
        req_tag_i    = tag;
        req_rd_i     = rd;
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 6'd0);
    endtask

    task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
            $error("[TB] check %s", name);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        stall_i = 1'b0; flush_valid_i = 1'b0; flush_tag_i = '0; rob_head_i = '0;
        mul_result_i = '0; div_done_i = 1'b0; div_result_i = '0;
        idle();
        #11;
        check_output("rst_wb_valid", wb_valid_o, 0);
        check_output("rst_bcast_valid", bcast_valid_o, 0);
        check_output("rst_busy", busy_o, 0);
        check_output("rst_div_req", div_req_o, 0);
        check_output("rst_div_kill", div_kill_o, 0);
        check_output("rst_mul_req", mul_req_o, 0);
        check_output("rst_wb_data", wb_data_o, 0);
        rst = 1'b1;

        // MUL 6*7, tag 3, rd 10 accepted at T0
        tick();
        mul_result_i = 32'd42;
        apply_stimulus(1'b1, 1'b0, 2'd0, 32'd6, 32'd7, 5'd3, 6'd10);
        check_output("mul_ready", req_ready_o, 1);
        check_output("mul_req", mul_req_o, 1);
        check_output("mul_a", mul_a_o, 6);
        check_output("mul_b", mul_b_o, 7);
        tick(); idle();
        check_output("mul_wb_t1", wb_valid_o, 0);
        tick(); idle();
        check_output("mul_wb_t2", wb_valid_o, 0);
`ifdef MULDIV_EARLY_WAKEUP_EN
        check_output("mul_bcast_t2", bcast_valid_o, 1);
        check_output("mul_bcast_rd_t2", bcast_rd_o, 10);
`else
        check_output("mul_bcast_t2", bcast_valid_o, 0);
`endif
        tick(); idle();
        check_output("mul_wb_t3", wb_valid_o, 1);
        check_output("mul_wb_tag", wb_tag_o, 3);
        check_output("mul_wb_rd", wb_rd_o, 10);
        check_output("mul_wb_data", wb_data_o, 42);
`ifdef MULDIV_EARLY_WAKEUP_EN
        check_output("mul_bcast_t3", bcast_valid_o, 0);
`else
        check_output("mul_bcast_t3", bcast_valid_o, 1);
        check_output("mul_bcast_rd_t3", bcast_rd_o, 10);
`endif
        tick(); idle();
        check_output("mul_wb_t4", wb_valid_o, 0);

        // DIV 35/7, tag 4, rd 12; done at T20
        tick();
        apply_stimulus(1'b1, 1'b1, 2'd0, 32'd35, 32'd7, 5'd4, 6'd12);
        check_output("div_ready", req_ready_o, 1);
        check_output("div_no_mul_req", mul_req_o, 0);
        tick(); idle();
        check_output("div_req_t1", div_req_o, 1);
        check_output("div_a", div_a_o, 35);
        check_output("div_b", div_b_o, 7);
        check_output("div_busy_t1", busy_o, 1);
        tick(); idle();
        check_output("div_req_t2", div_req_o, 0);
        for (int i = 0; i < 3; i++) tick();
        apply_stimulus(1'b1, 1'b1, 2'd0, 32'd1, 32'd1, 5'd6, 6'd13);
        check_output("div2_refused", req_ready_o, 0);
        check_output("div2_busy", busy_o, 1);
        tick(); idle();
        for (int i = 0; i < 14; i++) tick();
        div_done_i = 1'b1; div_result_i = 32'd5;
        idle();
        tick();
        div_done_i = 1'b0;
        idle();
        check_output("div_wb_valid", wb_valid_o, 1);
        check_output("div_wb_tag", wb_tag_o, 4);
        check_output("div_wb_rd", wb_rd_o, 12);
        check_output("div_wb_data", wb_data_o, 5);
        check_output("div_bcast", bcast_valid_o, 1);
        check_output("div_bcast_rd", bcast_rd_o, 12);
        check_output("div_busy_clear", busy_o, 0);
        tick(); idle();
        check_output("div_wb_t22", wb_valid_o, 0);

        // Collision: DIV tag 8 done at T10 together with MUL tag 9 tail
        tick();
        apply_stimulus(1'b1, 1'b1, 2'd0, 32'd90, 32'd10, 5'd8, 6'd20);
        tick(); idle();
        for (int i = 0; i < 7; i++) tick();
        mul_result_i = 32'd100;
        apply_stimulus(1'b1, 1'b0, 2'd0, 32'd10, 32'd10, 5'd9, 6'd21);
        check_output("col_mul_req", mul_req_o, 1);
        tick(); idle();
        tick();
        div_done_i = 1'b1; div_result_i = 32'd9;
        idle();
        check_output("col_wb_t10", wb_valid_o, 0);
        tick();
        div_done_i = 1'b0;
        apply_stimulus(1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 5'd0, 6'd0);
        check_output("col_ready_t11", req_ready_o, 0);
        check_output("col_busy_t11", busy_o, 1);
        check_output("col_wb_t11", wb_valid_o, 1);
        check_output("col_wb_tag_t11", wb_tag_o, 9);
        check_output("col_wb_data_t11", wb_data_o, 100);
        tick();
        apply_stimulus(1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 5'd0, 6'd0);
        check_output("col_ready_t12", req_ready_o, 1);
        check_output("col_busy_t12", busy_o, 0);
        check_output("col_wb_t12", wb_valid_o, 1);
        check_output("col_wb_tag_t12", wb_tag_o, 8);
        check_output("col_wb_rd_t12", wb_rd_o, 20);
        check_output("col_wb_data_t12", wb_data_o, 9);
        tick(); idle();
        check_output("col_wb_t13", wb_valid_o, 0);

        // Kill: DIV tag 7 in RUN, MUL tag 2 in flight, flush tag 5 with head 0
        tick();
        apply_stimulus(1'b1, 1'b1, 2'd0, 32'd50, 32'd5, 5'd7, 6'd22);
        tick(); idle();
        tick(); idle();
        tick();
        mul_result_i = 32'd12;
        apply_stimulus(1'b1, 1'b0, 2'd0, 32'd3, 32'd4, 5'd2, 6'd23);
        tick();
        flush_valid_i = 1'b1; flush_tag_i = 5'd5; rob_head_i = 5'd0;
        div_done_i = 1'b1; div_result_i = 32'd77;
        idle();
        check_output("kill_pulse", div_kill_o, 1);
        tick();
        flush_valid_i = 1'b0; div_done_i = 1'b0;
        idle();
        check_output("kill_pulse_end", div_kill_o, 0);
        check_output("kill_no_div_wb", wb_valid_o, 0);
        check_output("kill_busy", busy_o, 0);
        tick(); idle();
        check_output("kill_mul_wb", wb_valid_o, 1);
        check_output("kill_mul_tag", wb_tag_o, 2);
        check_output("kill_mul_data", wb_data_o, 12);
        tick(); idle();
        check_output("kill_wb_after", wb_valid_o, 0);
        tick();
        flush_valid_i = 1'b1; flush_tag_i = 5'd5;
        apply_stimulus(1'b1, 1'b0, 2'd0, 32'd1, 32'd1, 5'd6, 6'd24);
        check_output("samecyc_ready", req_ready_o, 1);
        check_output("samecyc_no_mul_req", mul_req_o, 0);
        tick();
        flush_valid_i = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            check_output("samecyc_no_wb", wb_valid_o, 0);
            tick(); idle();
        end

        // Stall T4-T6 with MUL tag 11 accepted at T3
        tick(); idle();
        tick(); idle();
        tick(); idle();
        tick();
        mul_result_i = 32'd81;
        apply_stimulus(1'b1, 1'b0, 2'd0, 32'd9, 32'd9, 5'd11, 6'd30);
        check_output("stall_mul_req", mul_req_o, 1);
        tick();
        stall_i = 1'b1;
        idle();
        check_output("stall_ready", req_ready_o, 0);
        tick();
        apply_stimulus(1'b1, 1'b0, 2'd0, 32'd2, 32'd2, 5'd12, 6'd31);
        check_output("stall_no_mul_req", mul_req_o, 0);
        tick(); idle();
        check_output("stall_wb_t6", wb_valid_o, 0);
        tick();
        stall_i = 1'b0;
        idle();
        check_output("stall_wb_t7", wb_valid_o, 0);
        tick(); idle();
        check_output("stall_wb_t8", wb_valid_o, 0);
`ifdef MULDIV_EARLY_WAKEUP_EN
        check_output("stall_bcast_t8", bcast_valid_o, 1);
`else
        check_output("stall_bcast_t8", bcast_valid_o, 0);
`endif
        tick(); idle();
        check_output("stall_wb_t9", wb_valid_o, 1);
        check_output("stall_wb_tag", wb_tag_o, 11);
        check_output("stall_wb_data", wb_data_o, 81);
`ifdef MULDIV_EARLY_WAKEUP_EN
        check_output("stall_bcast_t9", bcast_valid_o, 0);
`else
        check_output("stall_bcast_t9", bcast_valid_o, 1);
`endif
        tick(); idle();
        check_output("stall_wb_t10", wb_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
